// File: rtl/chess_lab_pkg.sv
// Shared types for the move sequencer: state encoding (mirrored on estado_db),
// coordinate width and the move record used by the memory interface.
package chess_lab_pkg;

  localparam int COORD_W    = 3;
  localparam int N_ENTRADAS = 3;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CARREGA = 4'd1;
  localparam logic [3:0] ST_MOSTRA  = 4'd2;
  localparam logic [3:0] ST_AGUARDA = 4'd3;
  localparam logic [3:0] ST_COMPARA = 4'd4;
  localparam logic [3:0] ST_PROXIMA = 4'd5;
  localparam logic [3:0] ST_GANHOU  = 4'd6;
  localparam logic [3:0] ST_ERRO    = 4'd7;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    CARREGA = ST_CARREGA,
    MOSTRA  = ST_MOSTRA,
    AGUARDA = ST_AGUARDA,
    COMPARA = ST_COMPARA,
    PROXIMA = ST_PROXIMA,
    GANHOU  = ST_GANHOU,
    ERRO    = ST_ERRO
  } estado_t;

  typedef struct packed {
    logic [COORD_W-1:0] coluna;
    logic [COORD_W-1:0] linha;
  } jogada_t;

endpackage

// File: rtl/sequenciador_jogadas_temporizador.sv
// Clear/enable up-counter that stops at MAX-1 and flags terminal count there.
module temporizador #(
  parameter int MAX = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt;

  assign fim = (cnt == W'(MAX - 1));

  // Saturates at the terminal count instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      cnt <= '0;
    end else if (conta && !fim) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sequenciador_jogadas.sv
// Game sequencer: loads/shows the 3 stored moves, checks player replies, shifts
// in a new move per round. Define TIMEOUT_EN to enable the per-move timeout.
module sequenciador_jogadas
  import chess_lab_pkg::*;
#(
  parameter int T_MOSTRA  = 50,
  parameter int T_JOGADA  = 1000,
  parameter int N_RODADAS = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               iniciar,
  input  logic                               jogar,
  input  logic [COORD_W-1:0]                 coluna_jogada,
  input  logic [COORD_W-1:0]                 linha_jogada,
  input  logic [COORD_W-1:0]                 coluna1,
  input  logic [COORD_W-1:0]                 linha1,
  input  logic [COORD_W-1:0]                 coluna2,
  input  logic [COORD_W-1:0]                 linha2,
  input  logic [COORD_W-1:0]                 coluna3,
  input  logic [COORD_W-1:0]                 linha3,
  output logic                               nova_jogada_init,
  output logic                               nova_jogada,
  output logic                               mostra_valida,
  output logic [COORD_W-1:0]                 mostra_coluna,
  output logic [COORD_W-1:0]                 mostra_linha,
  output logic                               aguardando,
  output logic                               acertou,
  output logic                               errou,
  output logic                               timeout,
  output logic [$clog2(N_RODADAS+1)-1:0]     rodada,
  output logic [3:0]                         estado_db
);

  localparam int         RW     = $clog2(N_RODADAS + 1);
  localparam logic [1:0] ULTIMA = 2'(N_ENTRADAS - 1);

  estado_t        estado, prox_estado;
  logic [1:0]     idx, idx_prox;
  logic [RW-1:0]  rodada_q, rodada_prox, rodada_inc;
  jogada_t        jog_reg, jog_prox, entrada;
  logic           timeout_q, timeout_prox;
  logic           fim_mostra, fim_jogada;

  temporizador #(.MAX(T_MOSTRA)) u_tmr_mostra (
    .clock (clock),
    .reset (reset),
    .limpa ((estado != MOSTRA) || fim_mostra),
    .conta (estado == MOSTRA),
    .fim   (fim_mostra)
  );

`ifdef TIMEOUT_EN
  temporizador #(.MAX(T_JOGADA)) u_tmr_jogada (
    .clock (clock),
    .reset (reset),
    .limpa (estado != AGUARDA),
    .conta (estado == AGUARDA),
    .fim   (fim_jogada)
  );
`else
  logic unused_t_jogada;
  assign unused_t_jogada = ^T_JOGADA;
  assign fim_jogada      = 1'b0;
`endif

  always_comb begin
    case (idx)
      2'd0:    entrada = '{coluna: coluna1, linha: linha1};
      2'd1:    entrada = '{coluna: coluna2, linha: linha2};
      default: entrada = '{coluna: coluna3, linha: linha3};
    endcase
  end

  assign rodada_inc = (rodada_q == RW'(N_RODADAS)) ? rodada_q : rodada_q + RW'(1);

  // NOTE: every signal written here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    prox_estado  = estado;
    idx_prox     = idx;
    rodada_prox  = rodada_q;
    jog_prox     = jog_reg;
    timeout_prox = timeout_q;
    case (estado)
      IDLE: if (iniciar) prox_estado = CARREGA;
      CARREGA: begin
        rodada_prox  = '0;
        idx_prox     = '0;
        timeout_prox = 1'b0;
        prox_estado  = MOSTRA;
      end
      MOSTRA: begin
        if (fim_mostra) begin
          if (idx == ULTIMA) begin
            idx_prox    = '0;
            prox_estado = AGUARDA;
          end else begin
            idx_prox = idx + 2'd1;
          end
        end
      end
      AGUARDA: begin
        // A reply in the expiry cycle still counts.
        if (jogar) begin
          jog_prox    = '{coluna: coluna_jogada, linha: linha_jogada};
          prox_estado = COMPARA;
        end else if (fim_jogada) begin
          timeout_prox = 1'b1;
          prox_estado  = ERRO;
        end
      end
      COMPARA: begin
        if (jog_reg != entrada) begin
          prox_estado = ERRO;
        end else if (idx != ULTIMA) begin
          idx_prox    = idx + 2'd1;
          prox_estado = AGUARDA;
        end else begin
          rodada_prox = rodada_inc;
          prox_estado = (rodada_inc == RW'(N_RODADAS)) ? GANHOU : PROXIMA;
        end
      end
      PROXIMA: begin
        idx_prox    = '0;
        prox_estado = MOSTRA;
      end
      GANHOU, ERRO: if (iniciar) prox_estado = CARREGA;
      default: prox_estado = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= IDLE;
      idx       <= '0;
      rodada_q  <= '0;
      jog_reg   <= '0;
      timeout_q <= 1'b0;
    end else begin
      estado    <= prox_estado;
      idx       <= idx_prox;
      rodada_q  <= rodada_prox;
      jog_reg   <= jog_prox;
      timeout_q <= timeout_prox;
    end
  end

  assign nova_jogada_init = (estado == CARREGA);
  assign nova_jogada      = (estado == PROXIMA);
  assign mostra_valida    = (estado == MOSTRA);
  assign mostra_coluna    = (estado == MOSTRA) ? entrada.coluna : '0;
  assign mostra_linha     = (estado == MOSTRA) ? entrada.linha  : '0;
  assign aguardando       = (estado == AGUARDA);
  assign acertou          = (estado == GANHOU);
  assign errou            = (estado == ERRO);
  assign timeout          = (estado == ERRO) && timeout_q;
  assign rodada           = rodada_q;
  assign estado_db        = estado;

endmodule

// File: tb/tb_sequenciador_jogadas.sv
// Scoreboard bench for sequenciador_jogadas: a behavioural move memory and game
// model push expected displays/outcomes; a negedge monitor pops and compares.
module tb_sequenciador_jogadas;
  import chess_lab_pkg::*;

  localparam int T_MOSTRA  = 3;
  localparam int T_JOGADA  = 10;
  localparam int N_RODADAS = 2;
  localparam int RW        = $clog2(N_RODADAS + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic          jogar = 1'b0;
  logic [2:0]    coluna_jogada = '0;
  logic [2:0]    linha_jogada = '0;
  logic          nova_jogada_init, nova_jogada, mostra_valida, aguardando;
  logic          acertou, errou, timeout;
  logic [2:0]    mostra_coluna, mostra_linha;
  logic [RW-1:0] rodada;
  logic [3:0]    estado_db;

  typedef struct {
    bit acertou;
    bit errou;
    bit timeout;
    int rodada;
    int novas;
  } result_t;

  jogada_t mem [3];
  jogada_t disp_q [$];
  result_t result_q [$];
  int      checks = 0;
  int      errors = 0;
  int      nova_count = 0;
  int      init_count = 0;
  bit      fim_prev = 1'b0;

  always #5 clock = ~clock;

  sequenciador_jogadas #(
    .T_MOSTRA (T_MOSTRA),
    .T_JOGADA (T_JOGADA),
    .N_RODADAS(N_RODADAS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogar           (jogar),
    .coluna_jogada   (coluna_jogada),
    .linha_jogada    (linha_jogada),
    .coluna1         (mem[0].coluna),
    .linha1          (mem[0].linha),
    .coluna2         (mem[1].coluna),
    .linha2          (mem[1].linha),
    .coluna3         (mem[2].coluna),
    .linha3          (mem[2].linha),
    .nova_jogada_init(nova_jogada_init),
    .nova_jogada     (nova_jogada),
    .mostra_valida   (mostra_valida),
    .mostra_coluna   (mostra_coluna),
    .mostra_linha    (mostra_linha),
    .aguardando      (aguardando),
    .acertou         (acertou),
    .errou           (errou),
    .timeout         (timeout),
    .rodada          (rodada),
    .estado_db       (estado_db)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string msg);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  function automatic jogada_t rand_move();
    jogada_t m;
    m.coluna = 3'($urandom_range(0, 7));
    m.linha  = 3'($urandom_range(0, 7));
    return m;
  endfunction

  // Passive move memory: every load/shift is followed by one full display pass.
  always @(posedge clock) begin
    jogada_t n [3];
    if (nova_jogada_init || nova_jogada) begin
      if (nova_jogada_init) begin
        for (int i = 0; i < 3; i++) n[i] = rand_move();
      end else begin
        n[0] = mem[1];
        n[1] = mem[2];
        n[2] = rand_move();
      end
      for (int i = 0; i < 3; i++) begin
        mem[i] <= n[i];
        for (int c = 0; c < T_MOSTRA; c++) disp_q.push_back(n[i]);
      end
    end
  end

  initial for (int i = 0; i < 3; i++) mem[i] = '0;

  always @(negedge clock) begin
    jogada_t esperado;
    result_t e;
    bit      fim;
    if (mostra_valida) begin
      if (disp_q.size() == 0) begin
        fail_now($sformatf("display_extra: shown (%0d,%0d) with nothing expected", mostra_coluna, mostra_linha));
      end else begin
        esperado = disp_q.pop_front();
        check("mostra_coluna", mostra_coluna, esperado.coluna);
        check("mostra_linha", mostra_linha, esperado.linha);
      end
    end
    if (nova_jogada || nova_jogada_init) check("pulsos_exclusivos", nova_jogada & nova_jogada_init, 0);
    if (nova_jogada) nova_count++;
    if (nova_jogada_init) init_count++;
    fim = acertou | errou;
    if (fim && !fim_prev) begin
      if (result_q.size() == 0) begin
        fail_now($sformatf("fim_inesperado: acertou=%0d errou=%0d", acertou, errou));
      end else begin
        e = result_q.pop_front();
        check("acertou", acertou, e.acertou);
        check("errou", errou, e.errou);
        check("timeout", timeout, e.timeout);
        check("rodada_final", rodada, e.rodada);
        check("pulsos_nova_jogada", nova_count, e.novas);
        check("pulsos_init", init_count, 1);
      end
    end
    fim_prev = fim;
  end

  task automatic check_all_zero(input string name);
    check(name, {nova_jogada_init, nova_jogada, mostra_valida, mostra_coluna, mostra_linha,
                 aguardando, acertou, errou, timeout, rodada, estado_db}, 0);
  endtask

  task automatic start_game();
    nova_count = 0;
    init_count = 0;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    check("latencia_iniciar_mostra", mostra_valida, 1);
  endtask

  task automatic wait_aguardando(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (aguardando) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) fail_now("wait_aguardando: no aguardando within 200 cycles");
  endtask

  task automatic wait_fim();
    for (int i = 0; i < 100 && result_q.size() != 0; i++) @(negedge clock);
    if (result_q.size() != 0) fail_now("wait_fim: expected outcome never reached");
  endtask

  task automatic send_move(input jogada_t m);
    jogar = 1'b1;
    coluna_jogada = m.coluna;
    linha_jogada = m.linha;
    @(negedge clock);
    jogar = 1'b0;
    coluna_jogada = 3'($urandom_range(0, 7));
    linha_jogada = 3'($urandom_range(0, 7));
    @(negedge clock);
  endtask

  // bad_round < 0 means the player never errs and must win.
  task automatic play_game(input int bad_round, input int bad_move);
    int      rounds;
    bit      lost, ok;
    jogada_t m;
    rounds = 0;
    lost = 1'b0;
    start_game();
    for (int r = 0; r < N_RODADAS && !lost; r++) begin
      for (int k = 0; k < 3 && !lost; k++) begin
        wait_aguardando(ok);
        if (!ok) return;
        if (k == 0) check("rodada_inicio_rodada", rodada, r);
        repeat ($urandom_range(0, 4)) @(negedge clock);
        m = mem[k];
        if (r == bad_round && k == bad_move) begin
          if ($urandom_range(0, 1) == 1) m.coluna = m.coluna ^ 3'($urandom_range(1, 7));
          else m.linha = m.linha ^ 3'($urandom_range(1, 7));
          lost = 1'b1;
          result_q.push_back('{acertou: 1'b0, errou: 1'b1, timeout: 1'b0, rodada: rounds, novas: rounds});
        end else if (k == 2 && rounds + 1 == N_RODADAS) begin
          result_q.push_back('{acertou: 1'b1, errou: 1'b0, timeout: 1'b0, rodada: N_RODADAS, novas: N_RODADAS - 1});
        end
        if (k == 2 && !lost) rounds++;
        send_move(m);
        if (!lost && k < 2) check("latencia_jogar_aguardando", aguardando, 1);
      end
    end
    wait_fim();
  endtask

  initial begin
    bit ok;
    int br;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_all_zero("estado_reset");

    play_game(-1, 0);
    play_game(0, 1);
    play_game(1, 0);
    for (int g = 0; g < 5; g++) begin
      br = $urandom_range(0, N_RODADAS);
      play_game((br == N_RODADAS) ? -1 : br, $urandom_range(0, 2));
    end

    // jogar and iniciar during MOSTRA are ignored; reset wins mid-game.
    start_game();
    iniciar = 1'b1;
    jogar = 1'b1;
    coluna_jogada = mem[0].coluna;
    linha_jogada = mem[0].linha;
    @(negedge clock);
    iniciar = 1'b0;
    jogar = 1'b0;
    check("mostra_ignora_jogar", estado_db, ST_MOSTRA);
    check("mostra_sem_aguardando", aguardando, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    disp_q.delete();
    check_all_zero("reset_meio_jogo");

`ifdef TIMEOUT_EN
    start_game();
    wait_aguardando(ok);
    result_q.push_back('{acertou: 1'b0, errou: 1'b1, timeout: 1'b1, rodada: 0, novas: 0});
    repeat (T_JOGADA - 1) @(negedge clock);
    check("ultimo_ciclo_sem_erro", errou, 0);
    @(negedge clock);
    check("timeout_errou", errou, 1);
    check("timeout_flag", timeout, 1);
    wait_fim();

    start_game();
    wait_aguardando(ok);
    repeat (T_JOGADA - 1) @(negedge clock);
    send_move(mem[0]);
    check("jogar_na_expiracao_sem_erro", errou, 0);
    check("jogar_na_expiracao_aceito", aguardando, 1);
    result_q.push_back('{acertou: 1'b0, errou: 1'b1, timeout: 1'b1, rodada: 0, novas: 0});
    wait_fim();
`else
    start_game();
    wait_aguardando(ok);
    repeat (5000) @(negedge clock);
    check("espera_longa_aguardando", aguardando, 1);
    check("espera_longa_sem_timeout", timeout, 0);
    check("espera_longa_sem_erro", errou, 0);
    result_q.push_back('{acertou: 1'b0, errou: 1'b1, timeout: 1'b0, rodada: 0, novas: 0});
    send_move('{coluna: mem[0].coluna ^ 3'd1, linha: mem[0].linha});
    wait_fim();
`endif

    repeat (2) @(negedge clock);
    check("fila_display_vazia", disp_q.size(), 0);
    check("fila_resultados_vazia", result_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
